// File: rtl/mrelbp_ci_rn.sv
// MRELBP centre-intensity stage: pass 1 buffers and sums interior centre values, pass 2 replays one
// "value >= frame mean" bit per pixel. Define MRELBP_CI_BACKPRESSURE_EN to add ci_ready_i flow control.
module mrelbp_ci_rn #(
  parameter int COLS = 19,
  parameter int ROWS = 19,
  parameter int R    = 1,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
`ifdef MRELBP_CI_BACKPRESSURE_EN
  input  logic          ci_ready_i,
`endif
  input  logic          start_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          ci_o,
  output logic          ci_valid_o,
  output logic          frame_done_o,
  output logic          busy_o
);

  localparam int N_PIX = (ROWS - 2*R) * (COLS - 2*R);
  localparam int AW    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int SUM_W = DW + AW;
  localparam int PW    = DW + AW + 1;
  localparam logic [AW-1:0] LAST = AW'(N_PIX - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, REPLAY} state_t;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             rd_done_q, rd_done_d;
  logic [3:1]       vld_pipe_q;
  logic [3:1]       last_pipe_q;
  logic             ci_q;
  logic [DW-1:0]    rd_val_q, cmp_val_q;
  logic [DW-1:0]    mem [N_PIX];

  logic             stall, issue, accept, frame_end, cmp_ge;
  logic [PW-1:0]    prod;

`ifdef MRELBP_CI_BACKPRESSURE_EN
  assign stall = vld_pipe_q[3] & ~ci_ready_i;
`else
  assign stall = 1'b0;
`endif

  assign accept    = (state_q == ACCUM) & valid_i & ~start_i;
  assign issue     = (state_q == REPLAY) & ~rd_done_q & ~stall;
  assign frame_end = vld_pipe_q[3] & last_pipe_q[3] & ~stall;

  // value*N_PIX >= sum is the division-free form of value >= mean
  assign prod   = PW'(cmp_val_q) * PW'(N_PIX);
  assign cmp_ge = prod >= PW'(sum_q);

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_done_d = rd_done_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = ACCUM;
          sum_d    = '0;
          wr_ptr_d = '0;
        end
      end
      ACCUM: begin
        if (start_i) begin
          sum_d    = '0;
          wr_ptr_d = '0;
        end else if (valid_i) begin
          sum_d    = sum_q + SUM_W'(data_i);
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST) begin
            state_d   = REPLAY;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            rd_done_d = 1'b0;
          end
        end
      end
      REPLAY: begin
        if (issue) begin
          if (rd_ptr_q == LAST) rd_done_d = 1'b1;
          else                  rd_ptr_d  = rd_ptr_q + 1'b1;
        end
        if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_done_q   <= 1'b0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      ci_q        <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_done_q <= rd_done_d;
      // whole read pipe freezes while the output result is held
      if (!stall) begin
        vld_pipe_q  <= {vld_pipe_q[2:1], issue};
        last_pipe_q <= {last_pipe_q[2:1], issue & (rd_ptr_q == LAST)};
        if (vld_pipe_q[2]) ci_q <= cmp_ge;
      end
    end
  end

  // Buffer and data path carry no reset; only the valid bits qualify them
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= data_i;
    if (!stall) begin
      if (issue)         rd_val_q  <= mem[rd_ptr_q];
      if (vld_pipe_q[1]) cmp_val_q <= rd_val_q;
    end
  end

  assign ready_o      = (state_q == ACCUM);
  assign busy_o       = (state_q != IDLE);
  assign ci_o         = ci_q;
  assign ci_valid_o   = vld_pipe_q[3];
  assign frame_done_o = last_pipe_q[3];

endmodule

// File: tb/tb_mrelbp_ci_rn.sv
// Bench for mrelbp_ci_rn: 5x5/R=1 (9 pixels) table and random frames, plus a 3x3 (1 pixel) instance.
module tb_mrelbp_ci_rn;
  localparam int N = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, start_i = 1'b0, valid_i = 1'b0, ci_ready = 1'b1;
  logic [7:0] data_i = '0;
  logic       ready_o, ci_o, ci_valid_o, frame_done_o, busy_o;

  logic       s_start = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, s_ci, s_civ, s_fd, s_busy;

  mrelbp_ci_rn #(.COLS(5), .ROWS(5), .R(1), .DW(8)) dut (
    .clk(clk), .rst(rst),
`ifdef MRELBP_CI_BACKPRESSURE_EN
    .ci_ready_i(ci_ready),
`endif
    .start_i(start_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .ci_o(ci_o), .ci_valid_o(ci_valid_o),
    .frame_done_o(frame_done_o), .busy_o(busy_o));

  mrelbp_ci_rn #(.COLS(3), .ROWS(3), .R(1), .DW(8)) dut1 (
    .clk(clk), .rst(rst),
`ifdef MRELBP_CI_BACKPRESSURE_EN
    .ci_ready_i(1'b1),
`endif
    .start_i(s_start), .valid_i(s_valid), .data_i(s_data),
    .ready_o(s_ready), .ci_o(s_ci), .ci_valid_o(s_civ),
    .frame_done_o(s_fd), .busy_o(s_busy));

  int passed = 0, total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Result collector: one entry per transfer; optional ready stalls on results 3 and 7
  bit   res_q[$];
  bit   fd_q[$];
  int   t_q[$];
  int   orphan = 0, stall_left = 0, xfer = 0;
  bit   bp_mode = 1'b0;
  bit   stalled[N];
  logic held_ci, held_fd;

  always @(negedge clk) begin
    if (frame_done_o && !ci_valid_o) orphan++;
    if (stall_left > 0) begin
      chk("bp_hold", {ci_valid_o, ci_o, frame_done_o}, {1'b1, held_ci, held_fd});
      stall_left--;
      if (stall_left == 0) ci_ready = 1'b1;
    end else if (ci_valid_o) begin
      if (bp_mode && (xfer == 2 || xfer == 6) && !stalled[xfer]) begin
        ci_ready = 1'b0; stall_left = 4; stalled[xfer] = 1'b1;
        held_ci = ci_o; held_fd = frame_done_o;
      end else if (ci_ready) begin
        res_q.push_back(ci_o); fd_q.push_back(frame_done_o); t_q.push_back(cyc); xfer++;
      end
    end
  end

  // Reference: a pixel's bit is set when it is at or above the frame mean
  function automatic logic [8:0] model(input logic [8:0][7:0] p);
    int s = 0;
    logic [8:0] m;
    for (int i = 0; i < N; i++) s += int'(p[i]);
    for (int i = 0; i < N; i++) m[i] = (int'(p[i]) * N >= s);
    return m;
  endfunction

  typedef struct {
    string           name;
    logic [8:0][7:0] pix;
    bit              gaps, pre, noise, sv, bp;
    logic [8:0]      exp;
  } vec_t;
  vec_t tbl[$];

  task automatic run_frame(input vec_t v);
    int c_last, lat;
    bit seen;
    logic [8:0] got, fdv;
    res_q.delete(); fd_q.delete(); t_q.delete();
    xfer = 0;
    for (int i = 0; i < N; i++) stalled[i] = 1'b0;
    bp_mode = v.bp;
    @(posedge clk); #1;
    start_i = 1'b1; valid_i = v.sv; data_i = 8'd250;
    @(posedge clk); #1;
    start_i = 1'b0; valid_i = 1'b0;
    if (v.pre) begin
      for (int i = 0; i < 5; i++) begin
        valid_i = 1'b1; data_i = 8'd9; @(posedge clk); #1;
      end
      valid_i = 1'b0; start_i = 1'b1; @(posedge clk); #1; start_i = 1'b0;
    end
    chk({v.name, "_busy_ready"}, {busy_o, ready_o}, 2'b11);
    for (int i = 0; i < N; i++) begin
      if (v.gaps) while ($urandom_range(1, 0) == 1) begin @(posedge clk); #1; end
      valid_i = 1'b1; data_i = v.pix[i];
      @(posedge clk); #1;
      valid_i = 1'b0;
    end
    c_last = cyc;
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (k == 0) chk({v.name, "_ready_replay"}, ready_o, 0);
      if (v.noise) begin
        valid_i = 1'($urandom_range(1, 0)); data_i = 8'($urandom); start_i = (k == 1);
      end
      if (frame_done_o) begin
        seen = 1'b1;
        chk({v.name, "_busy_at_done"}, busy_o, 1);
      end
    end
    valid_i = 1'b0; start_i = 1'b0;
    chk({v.name, "_done_seen"}, seen, 1);
    @(negedge clk);
    chk({v.name, "_busy_after"}, busy_o, 0);
    repeat (3) @(negedge clk);
    got = '0; fdv = '0;
    for (int i = 0; i < res_q.size() && i < N; i++) begin got[i] = res_q[i]; fdv[i] = fd_q[i]; end
    lat = (t_q.size() > 0) ? t_q[0] - c_last : -1;
    chk({v.name, "_count"}, res_q.size(), N);
    chk({v.name, "_ci"}, got, v.exp);
    chk({v.name, "_fd"}, fdv, 9'h100);
    chk({v.name, "_latency"}, lat, 3);
    bp_mode = 1'b0;
  endtask

  function automatic vec_t mk(input string n, input logic [8:0][7:0] p,
                              input bit g, pr, no, sv, bp, input logic [8:0] e);
    vec_t v;
    v.name = n; v.pix = p; v.gaps = g; v.pre = pr; v.noise = no; v.sv = sv; v.bp = bp; v.exp = e;
    return v;
  endfunction

  initial begin
    logic [8:0][7:0] seq, sat, sev, rp;
    bit got1;
    for (int i = 0; i < N; i++) begin
      seq[i] = 8'(i + 1); sat[i] = (i < 8) ? 8'd255 : 8'd0; sev[i] = 8'd7;
    end
    tbl.push_back(mk("seq",       seq, 0, 0, 0, 0, 0, 9'b111110000));
    tbl.push_back(mk("sat",       sat, 0, 0, 0, 0, 0, 9'b011111111));
    tbl.push_back(mk("restart",   seq, 0, 1, 1, 0, 0, 9'b111110000));
    tbl.push_back(mk("gaps",      seq, 1, 0, 0, 0, 0, 9'b111110000));
    tbl.push_back(mk("startvld",  seq, 0, 0, 0, 1, 0, 9'b111110000));
`ifdef MRELBP_CI_BACKPRESSURE_EN
    tbl.push_back(mk("backpress", seq, 0, 0, 0, 0, 1, 9'b111110000));
`endif

    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", {ready_o, ci_o, ci_valid_o, frame_done_o, busy_o}, 0);
    @(negedge clk); rst = 1'b1;

    // abort mid-ACCUM: pre-reset pixels must not leak into the next frame
    @(posedge clk); #1; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin valid_i = 1'b1; data_i = 8'd200; @(posedge clk); #1; end
    valid_i = 1'b0;
    chk("busy_before_abort", busy_o, 1);
    rst = 1'b0; #2;
    chk("async_reset", {ready_o, ci_valid_o, frame_done_o, busy_o}, 0);
    @(negedge clk); rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_partial", res_q.size(), 0);
    run_frame(mk("post_reset", sev, 0, 0, 0, 0, 0, 9'h1FF));

    foreach (tbl[i]) run_frame(tbl[i]);

    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < N; i++) rp[i] = (f % 3 == 0) ? 8'($urandom_range(3, 0)) : 8'($urandom);
      run_frame(mk($sformatf("rand%0d", f), rp, f[0], 0, f[1], 0, 0, model(rp)));
    end

    // single-pixel frame always reports ci=1
    for (int f = 0; f < 2; f++) begin
      @(posedge clk); #1; s_start = 1'b1;
      @(posedge clk); #1; s_start = 1'b0; s_valid = 1'b1; s_data = (f == 0) ? 8'd0 : 8'($urandom);
      @(posedge clk); #1; s_valid = 1'b0;
      got1 = 1'b0;
      for (int k = 0; k < 10 && !got1; k++) begin
        @(negedge clk);
        if (s_civ) begin
          got1 = 1'b1;
          chk($sformatf("npix1_ci%0d", f), {s_ci, s_fd}, 2'b11);
        end
      end
      chk($sformatf("npix1_seen%0d", f), got1, 1);
      @(negedge clk);
      chk($sformatf("npix1_idle%0d", f), s_busy, 0);
    end

    chk("fd_orphan", orphan, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
